// File: rtl/rf_pkg.sv
// Shared constants for the 2-read/1-write register file.
package rf_pkg;
    localparam int RF_WIDTH    = 16;
    localparam int RF_ADDR_W   = 3;
    localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;
endpackage

// File: rtl/dff.sv
// Single-bit flop with asynchronous active-high clear.
module dff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end
endmodule

// File: rtl/register16.sv
// Enable register cell with asynchronous active-high clear.
module register16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file with per-register written flags.
// Optional write-before-read forwarding is enabled with `define REGFILE_BYPASS_EN.
module regfile_2r1w
    import rf_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read1regsel,
    input  logic [ADDR_W-1:0] read2regsel,
    input  logic [ADDR_W-1:0] writeregsel,
    input  logic [WIDTH-1:0]  writedata,
    input  logic              write,
    output logic [WIDTH-1:0]  read1data,
    output logic [WIDTH-1:0]  read2data,
    output logic              read1valid,
    output logic              read2valid
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    logic [NUM_REGS-1:0]            written;
    logic [NUM_REGS-1:0]            we;

    always_comb begin
        we = '0;
        we[writeregsel] = write;
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        register16 #(.WIDTH(WIDTH)) u_data (
            .clk (clk),
            .rst (rst),
            .en  (we[i]),
            .d   (writedata),
            .q   (regs[i])
        );

        // Sticky: once set, only reset clears it.
        dff u_flag (
            .clk (clk),
            .rst (rst),
            .d   (written[i] | we[i]),
            .q   (written[i])
        );
    end

`ifdef REGFILE_BYPASS_EN
    logic byp1, byp2;
    assign byp1 = write && !rst && (writeregsel == read1regsel);
    assign byp2 = write && !rst && (writeregsel == read2regsel);

    assign read1data  = byp1 ? writedata : regs[read1regsel];
    assign read2data  = byp2 ? writedata : regs[read2regsel];
    assign read1valid = byp1 | written[read1regsel];
    assign read2valid = byp2 | written[read2regsel];
`else
    assign read1data  = regs[read1regsel];
    assign read2data  = regs[read2regsel];
    assign read1valid = written[read1regsel];
    assign read2valid = written[read2regsel];
`endif
endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter WIDTH, default 16, data bits per register.
REQ-002 Parameter ADDR_W, default 3, register select width; NUM_REGS = 2**ADDR_W (8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 read1regsel  input  ADDR_W  select for read port 1.
REQ-006 read2regsel  input  ADDR_W  select for read port 2.
REQ-007 writeregsel  input  ADDR_W  select for write port.
REQ-008 writedata  input  WIDTH  data to store.
REQ-009 write  input  1  write enable; store writedata at writeregsel on rising edge.
REQ-010 read1data  output  WIDTH  contents of register read1regsel.
REQ-011 read2data  output  WIDTH  contents of register read2regsel.
REQ-012 read1valid  output  1  register read1regsel has been written since last reset.
REQ-013 read2valid  output  1  register read2regsel has been written since last reset.

Function
REQ-014 The block SHALL hold NUM_REGS registers of WIDTH bits, each updated only when write=1 and writeregsel selects it; all others hold their value.
REQ-015 Read ports SHALL be combinational from the selects; zero-cycle read latency; both ports are independent and may select the same register.
REQ-016 The block SHALL keep one written flag per register: set on the rising edge of a write to it, never cleared except by reset.
REQ-017 readNvalid SHALL equal the written flag of the selected register, subject to the same bypass rule as the data (REQ-024/025).
REQ-018 Write with write=0 SHALL change neither data nor flags, regardless of writeregsel/writedata.
REQ-019 Consecutive-cycle writes to the same register SHALL each take effect; the last write wins.
REQ-020 Read of a register in the same cycle it is written, bypass disabled: readNdata SHALL show the old value until the edge, the new value after it.
REQ-021 No X SHALL propagate to outputs after reset for any in-range select.

Reset
REQ-022 While rst=1, all registers SHALL be 0 and all written flags 0, asynchronously, independent of clk; hence read1data=read2data=0 and read1valid=read2valid=0.
REQ-023 A write coinciding with rst=1 SHALL be discarded; the first write taking effect is on the first rising edge with rst=0.

Configuration
REQ-024 With macro REGFILE_BYPASS_EN defined: when write=1 and writeregsel==readNregsel, readNdata SHALL equal writedata and readNvalid SHALL be 1 combinationally in the same cycle (write-before-read); bypass is suppressed while rst=1.
REQ-025 Without REGFILE_BYPASS_EN: no bypass path is built; reads always return stored contents per REQ-020.

Structure
REQ-026 Constants WIDTH, ADDR_W, NUM_REGS defaults SHALL live in shared package rf_pkg; the module parameters default from it.
REQ-027 Each storage entry SHALL be an instance of the team's existing enable-register cell register16 (one per register, enable = write AND select decode); written flags SHALL use the team's dff cell.
REQ-028 Write-select decode, read muxes, and optional bypass SHALL be in regfile_2r1w itself; no other sub-module.

Verification
REQ-029 Reset: assert rst mid-operation after writing R3=16'hBEEF -> immediately read1data=0 and read1valid=0 for R3 with no clock edge.
REQ-030 Write/read: write R5=16'h1234, next cycle read1regsel=5 and read2regsel=5 -> both ports 16'h1234, both valid=1; R4 reads 0 with valid=0.
REQ-031 Write disabled: write=0, writeregsel=2, writedata=16'hFFFF for 3 cycles -> R2 stays 0 and read1valid for R2 stays 0.
REQ-032 Back-to-back: write R7=16'h0001 then R7=16'h0002 on consecutive edges -> R7 reads 16'h0002 after the second edge.
REQ-033 Same-cycle read/write of R1 (old 16'hAAAA, new 16'h5555): with REGFILE_BYPASS_EN read1data=16'h5555 before the edge; without it 16'hAAAA before and 16'h5555 after.
REQ-034 Write during reset: write R0=16'hCAFE with rst=1, release rst -> R0 reads 0, read1valid=0.
